// File: rtl/cook_timer.sv
// BCD mm:ss countdown timer for the magnetron controller: keypad digit entry,
// one-second countdown while mag_on is high, timer_done when the display reads 00:00.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int CNT_W         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       mag_on,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       sec_tick
);

  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [3:0]       min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic             done_d, tick_d;
  logic             key_ok;

  // A key is accepted only if it is a decimal digit and the digit it pushes
  // into sec_tens stays within 0-5.
  assign key_ok = key_valid && (key_digit <= 4'd9) && (sec_ones <= 4'd5);

  always_comb begin
    min_tens_d = min_tens;
    min_ones_d = min_ones;
    sec_tens_d = sec_tens;
    sec_ones_d = sec_ones;
    presc_d    = '0;
    tick_d     = 1'b0;

    if (!clearn) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (mag_on) begin
      if (!timer_done) begin
        if (presc_q == PRESC_MAX) begin
          tick_d = 1'b1;
          // Borrow chain; timer_done low guarantees a nonzero value here.
          if (sec_ones != 4'd0) begin
            sec_ones_d = sec_ones - 4'd1;
          end else begin
            sec_ones_d = 4'd9;
            if (sec_tens != 4'd0) begin
              sec_tens_d = sec_tens - 4'd1;
            end else begin
              sec_tens_d = 4'd5;
              if (min_ones != 4'd0) begin
                min_ones_d = min_ones - 4'd1;
              end else begin
                min_ones_d = 4'd9;
                min_tens_d = min_tens - 4'd1;
              end
            end
          end
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
    end else if (key_ok) begin
      min_tens_d = min_ones;
      min_ones_d = sec_tens;
      sec_tens_d = sec_ones;
      sec_ones_d = key_digit;
    end

    done_d = (min_tens_d == 4'd0) && (min_ones_d == 4'd0) &&
             (sec_tens_d == 4'd0) && (sec_ones_d == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b1;
      sec_tick   <= 1'b0;
      presc_q    <= '0;
    end else begin
      min_tens   <= min_tens_d;
      min_ones   <= min_ones_d;
      sec_tens   <= sec_tens_d;
      sec_ones   <= sec_ones_d;
      timer_done <= done_d;
      sec_tick   <= tick_d;
      presc_q    <= presc_d;
    end
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD countdown timer (mm:ss) that produces the timer_done input of the magnetron controller and consumes its mag_on output.
- Cook time is entered digit-by-digit from the keypad encoder and counts down once per second while mag_on is high.
- Digit outputs drive the 7-segment display stage.

Parameters:
- TICKS_PER_SEC, default 100, clk cycles per one-second countdown step (must be >= 2).
- CNT_W, default 7, prescaler width (must satisfy 2^CNT_W >= TICKS_PER_SEC).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- clearn  input  1  active-low clear of the entered/remaining time
- key_valid  input  1  one-cycle strobe, key_digit is valid
- key_digit  input  4  keypad digit, binary 0-9
- mag_on  input  1  magnetron running, from the magnetron controller
- min_tens  output  4  BCD minutes tens digit
- min_ones  output  4  BCD minutes ones digit
- sec_tens  output  4  BCD seconds tens digit (0-5)
- sec_ones  output  4  BCD seconds ones digit
- timer_done  output  1  high when all four digits are zero
- sec_tick  output  1  one-cycle pulse on every countdown step

Behaviour:
- One clock; reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values:
  - all digits 0
  - timer_done = 1
  - sec_tick = 0
  - prescaler = 0
- Priority each cycle, highest first: reset, then clearn == 0, then countdown (mag_on == 1), then key entry (mag_on == 0).
- clearn == 0:
  - All digits go to 0 and the prescaler goes to 0.
  - timer_done = 1 on the next edge.
  - Clearing is level-sensitive; all keys are ignored while clearn is held low.
- Key entry (mag_on == 0 and key_valid == 1):
  - Ignore the key if key_digit > 9.
  - Ignore the key if the current sec_ones > 5, because it would shift into sec_tens illegally.
  - Otherwise shift left in one cycle: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit.
  - The old min_tens is discarded.
  - timer_done updates on the same edge to reflect the new digits.
- Keys while mag_on == 1 are ignored.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while mag_on == 1 and timer_done == 0.
  - Held at 0 otherwise, so the first step after a start is always a full second.
  - On the cycle the prescaler equals TICKS_PER_SEC-1, it wraps to 0, the countdown step occurs, and sec_tick = 1 for that one cycle (registered, aligned with the digit update).
- Countdown step, as a BCD borrow chain:
  - sec_ones decrements; 0 wraps to 9 and borrows.
  - sec_tens decrements on borrow; 0 wraps to 5 and borrows.
  - min_ones decrements on borrow; 0 wraps to 9 and borrows.
  - min_tens decrements on borrow.
  - Example: 10:00 -> 09:59.
- Zero:
  - The step that reaches 00:00 sets timer_done = 1 on that same edge.
  - No further steps occur and no wrap below zero; the prescaler holds at 0.
- timer_done is a registered flag, equal to (all four next-state digits == 0).
- mag_on falling mid-second:
  - Prescaler returns to 0 and digits hold (pause).
  - A restart begins a fresh full second.
- mag_on == 1 with timer_done == 1: no activity.
- Maximum time is 99:59. Any value reachable by key entry is legal, since sec_tens can never exceed 5.

Test Plan (TICKS_PER_SEC = 4):
1. Reset: assert reset 2 cycles -> all digits 0, timer_done = 1, sec_tick = 0. Then press keys 1,3,0 with mag_on = 0 -> display 01:30, timer_done = 0 one cycle after the last key.
2. Countdown across a borrow: load 01:00, raise mag_on -> first sec_tick 4 cycles later, digits 00:59. After 59 further ticks, 00:00 with timer_done = 1 on the same edge. Holding mag_on for 20 more cycles leaves digits and sec_tick at 0.
3. Pause/resume: load 00:05, mag_on high for 6 cycles (one step -> 00:04), mag_on low for 10 cycles -> 00:04 holds, no ticks. mag_on high again -> next step exactly 4 cycles later (00:03).
4. Illegal and ignored keys:
   - With display 00:07, key 2 -> ignored, display stays 00:07 (sec_ones > 5).
   - Key 12 -> ignored.
   - Key 5 while mag_on = 1 -> ignored.
5. Clear priority: during countdown at 00:42, assert clearn = 0 together with mag_on = 1 and key_valid = 1 -> next edge 00:00, timer_done = 1, prescaler 0, no sec_tick.
6. Reset mid-countdown: at 12:34 with the prescaler at 2, assert reset -> next edge matches the reset values. After releasing reset with mag_on still 1 -> no ticks, because timer_done = 1.
